// File: rtl/ccr_pkg.sv
// ccr_pkg: shared definitions for the condition-code register and its consumers
// (ALU, decode, branch unit).
//   FLAG_Z/FLAG_N/FLAG_C : bit positions of the flags inside the CCR
//   br_cond_e            : jump condition encodings carried from decode
//   ccr_state_e          : interrupt-context state of the branch unit
package ccr_pkg;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic [1:0] {
    COND_JMP = 2'b00,
    COND_JZ  = 2'b01,
    COND_JN  = 2'b10,
    COND_JC  = 2'b11
  } br_cond_e;

  typedef enum logic {
    StNormal = 1'b0,
    StInInt  = 1'b1
  } ccr_state_e;

endpackage

// File: rtl/ccr_cond_eval.sv
// ccr_cond_eval: combinational jump-condition evaluator.
//   ccr      in  FLAG_W  registered condition codes
//   br_cond  in  2       jump condition (JMP/JZ/JN/JC)
//   take     out 1       condition satisfied
//   clr_mask out FLAG_W  flag to clear if the jump is taken
// Build option: BRANCH_FLAG_CLEAR_EN enables clearing the tested flag on a
// taken conditional jump; when undefined clr_mask is always zero.
module ccr_cond_eval #(
  parameter int unsigned FLAG_W = 3
) (
  input  logic [FLAG_W-1:0] ccr,
  input  logic [1:0]        br_cond,
  output logic              take,
  output logic [FLAG_W-1:0] clr_mask
);
  import ccr_pkg::*;

`ifdef BRANCH_FLAG_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  // Only bits Z/N/C are ever tested; wider CCR bits are plain storage.
  always_comb begin
    take     = 1'b0;
    clr_mask = '0;
    unique case (br_cond)
      COND_JMP: take = 1'b1;
      COND_JZ: begin
        take             = ccr[FLAG_Z];
        clr_mask[FLAG_Z] = ClrEn;
      end
      COND_JN: begin
        take             = ccr[FLAG_N];
        clr_mask[FLAG_N] = ClrEn;
      end
      COND_JC: begin
        take             = ccr[FLAG_C];
        clr_mask[FLAG_C] = ClrEn;
      end
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// ccr_branch_unit: execute-stage CCR owner, jump resolver and interrupt
// CCR save/restore.
//   clk, rst_n          clock, asynchronous active-low reset
//   flag_in, flag_we    per-flag write data / enables from the ALU
//   br_en, br_cond      jump in execute and its condition
//   br_target           jump destination
//   int_req             level interrupt request, held until int_ack
//   rti                 return-from-interrupt in execute
//   ccr_out             registered CCR
//   br_taken, br_pc     one-cycle redirect pulse and address (br_pc holds)
//   flush               squash younger stages (same as br_taken)
//   int_ack             one-cycle pulse: CCR saved, interrupt accepted
//   in_int              high while in the interrupt context
// Build option: BRANCH_FLAG_CLEAR_EN (see ccr_cond_eval).
module ccr_branch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic [FLAG_W-1:0] flag_we,
  input  logic              br_en,
  input  logic [1:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              int_req,
  input  logic              rti,
  output logic [FLAG_W-1:0] ccr_out,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_pc,
  output logic              flush,
  output logic              int_ack,
  output logic              in_int
);
  import ccr_pkg::*;

  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [FLAG_W-1:0] shadow_q, shadow_d;
  ccr_state_e        state_q, state_d;
  logic              br_taken_q, br_taken_d;
  logic [ADDR_W-1:0] br_pc_q, br_pc_d;
  logic              int_ack_q, int_ack_d;

  logic              take;
  logic [FLAG_W-1:0] clr_mask;
  logic              squash;
  logic              br_fire;
  logic [FLAG_W-1:0] we_eff;
  logic [FLAG_W-1:0] clr_eff;
  logic [FLAG_W-1:0] ccr_wr;

  // Evaluated on the registered CCR, so same-cycle flag writes never affect it.
  ccr_cond_eval #(
    .FLAG_W(FLAG_W)
  ) u_cond_eval (
    .ccr     (ccr_q),
    .br_cond (br_cond),
    .take    (take),
    .clr_mask(clr_mask)
  );

  always_comb begin
    // The instruction behind a taken jump is squashed: drop its side effects.
    squash  = br_taken_q;
    br_fire = br_en & ~squash & take;
    we_eff  = squash ? '0 : flag_we;
    clr_eff = br_fire ? clr_mask : '0;
    // Clear applied after the write so it wins on the tested bit.
    ccr_wr  = ((ccr_q & ~we_eff) | (flag_in & we_eff)) & ~clr_eff;

    ccr_d      = ccr_wr;
    shadow_d   = shadow_q;
    state_d    = state_q;
    int_ack_d  = 1'b0;
    br_taken_d = br_fire;
    br_pc_d    = br_fire ? br_target : br_pc_q;

    unique case (state_q)
      StNormal: begin
        if (int_req) begin
          shadow_d  = ccr_wr;
          state_d   = StInInt;
          int_ack_d = 1'b1;
        end
      end
      StInInt: begin
        // Pending int_req is not seen here; it is re-accepted from StNormal.
        if (rti && !squash) begin
          ccr_d   = shadow_q;
          state_d = StNormal;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q      <= '0;
      shadow_q   <= '0;
      state_q    <= StNormal;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      int_ack_q  <= 1'b0;
    end else begin
      ccr_q      <= ccr_d;
      shadow_q   <= shadow_d;
      state_q    <= state_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
      int_ack_q  <= int_ack_d;
    end
  end

  assign ccr_out  = ccr_q;
  assign br_taken = br_taken_q;
  assign flush    = br_taken_q;
  assign br_pc    = br_pc_q;
  assign int_ack  = int_ack_q;
  assign in_int   = (state_q == StInInt);

endmodule

// File: tb/tb_ccr_branch_unit.sv
// tb_ccr_branch_unit: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the CCR / branch / interrupt rules.
module tb_ccr_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  flag_in;
  logic [2:0]  flag_we;
  logic        br_en;
  logic [1:0]  br_cond;
  logic [15:0] br_target;
  logic        int_req;
  logic        rti;
  logic [2:0]  ccr_out;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        flush;
  logic        int_ack;
  logic        in_int;

  int errors;
  int checks;

  // Reference model state
  logic [2:0]  m_ccr;
  logic [2:0]  m_shadow;
  bit          m_in_int;
  bit          m_taken;
  logic [15:0] m_pc;
  bit          m_ack;

  ccr_branch_unit #(
    .ADDR_W(16),
    .FLAG_W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flag_in),
    .flag_we  (flag_we),
    .br_en    (br_en),
    .br_cond  (br_cond),
    .br_target(br_target),
    .int_req  (int_req),
    .rti      (rti),
    .ccr_out  (ccr_out),
    .br_taken (br_taken),
    .br_pc    (br_pc),
    .flush    (flush),
    .int_ack  (int_ack),
    .in_int   (in_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ccr    = '0;
    m_shadow = '0;
    m_in_int = 0;
    m_taken  = 0;
    m_pc     = '0;
    m_ack    = 0;
  endtask

  // One clock of the architectural rules, using the current inputs.
  task automatic model_step();
    bit          squashed;
    bit          cond_true;
    bit          take;
    logic [2:0]  nxt;
    bit          ack;
    squashed = m_taken;
    case (br_cond)
      2'd0:    cond_true = 1;
      2'd1:    cond_true = m_ccr[0];
      2'd2:    cond_true = m_ccr[1];
      default: cond_true = m_ccr[2];
    endcase
    take = br_en && !squashed && cond_true;
    nxt  = m_ccr;
    if (!squashed)
      for (int i = 0; i < 3; i++)
        if (flag_we[i]) nxt[i] = flag_in[i];
`ifdef BRANCH_FLAG_CLEAR_EN
    // JZ/JN/JC test bit (code-1); that bit is cleared when taken.
    if (take && br_cond != 2'd0) nxt[int'(br_cond) - 1] = 1'b0;
`endif
    ack = 0;
    if (!m_in_int) begin
      if (int_req) begin
        m_shadow = nxt;
        m_in_int = 1;
        ack      = 1;
      end
    end else if (rti && !squashed) begin
      nxt      = m_shadow;
      m_in_int = 0;
    end
    m_ccr   = nxt;
    m_taken = take;
    if (take) m_pc = br_target;
    m_ack = ack;
  endtask

  task automatic check_all();
    check("ccr_out", 32'(ccr_out), 32'(m_ccr));
    check("br_taken", 32'(br_taken), 32'(m_taken));
    check("flush", 32'(flush), 32'(m_taken));
    check("br_pc", 32'(br_pc), 32'(m_pc));
    check("int_ack", 32'(int_ack), 32'(m_ack));
    check("in_int", 32'(in_int), 32'(m_in_int));
  endtask

  // Drive one cycle of inputs (called at negedge), advance model, check at next negedge.
  task automatic cycle(input logic [2:0] we, input logic [2:0] fin, input logic ben,
                       input logic [1:0] cond, input logic [15:0] tgt, input logic ireq,
                       input logic r);
    flag_we   = we;
    flag_in   = fin;
    br_en     = ben;
    br_cond   = cond;
    br_target = tgt;
    int_req   = ireq;
    rti       = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic set_ccr(input logic [2:0] v);
    cycle(3'b111, v, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bit hold_req;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    flag_in   = '0;
    flag_we   = '0;
    br_en     = 1'b0;
    br_cond   = '0;
    br_target = '0;
    int_req   = 1'b0;
    rti       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ccr", 32'(ccr_out), 32'd0);
    check("rst_taken", 32'(br_taken), 32'd0);
    check("rst_in_int", 32'(in_int), 32'd0);
    rst_n = 1'b1;

    // Flag write
    cycle(3'b111, 3'b101, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    check("wr_101", 32'(ccr_out), 32'h5);

    // Taken JZ, then flush cycle, then JN not taken
    set_ccr(3'b001);
    cycle(3'b000, 3'b000, 1'b1, 2'd1, 16'h0040, 1'b0, 1'b0);
    check("jz_taken", 32'(br_taken), 32'd1);
    check("jz_pc", 32'(br_pc), 32'h0040);
`ifdef BRANCH_FLAG_CLEAR_EN
    check("jz_clear", 32'(ccr_out), 32'h0);
`else
    check("jz_noclear", 32'(ccr_out), 32'h1);
`endif
    idle();
    check("pulse_drop", 32'(br_taken), 32'd0);
    set_ccr(3'b001);
    cycle(3'b000, 3'b000, 1'b1, 2'd2, 16'h0080, 1'b0, 1'b0);
    check("jn_not_taken", 32'(br_taken), 32'd0);
    check("pc_hold", 32'(br_pc), 32'h0040);

    // Branch uses old CCR despite same-cycle write
    set_ccr(3'b000);
    cycle(3'b001, 3'b001, 1'b1, 2'd1, 16'h0100, 1'b0, 1'b0);
    check("old_ccr_used", 32'(br_taken), 32'd0);
    check("same_cyc_wr", 32'(ccr_out), 32'h1);

    // Interrupt save / restore with pending second request
    set_ccr(3'b110);
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    check("int_ack", 32'(int_ack), 32'd1);
    check("int_in", 32'(in_int), 32'd1);
    set_ccr(3'b001);
    check("int_ack_once", 32'(int_ack), 32'd0);
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    check("no_nest", 32'(int_ack), 32'd0);
    cycle(3'b111, 3'b011, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1);
    check("rti_restore", 32'(ccr_out), 32'h6);
    check("rti_out", 32'(in_int), 32'd0);
    check("rti_no_ack", 32'(int_ack), 32'd0);
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    check("pend_ack", 32'(int_ack), 32'd1);
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    check("rti2", 32'(in_int), 32'd0);

    // RTI in NORMAL ignored
    set_ccr(3'b010);
    cycle(3'b000, 3'b000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    check("rti_norm_ccr", 32'(ccr_out), 32'h2);
    check("rti_norm_st", 32'(in_int), 32'd0);

    // JMP then JC during flush cycle: squashed
    set_ccr(3'b110);
    cycle(3'b000, 3'b000, 1'b1, 2'd0, 16'h1234, 1'b0, 1'b0);
    check("jmp_pc", 32'(br_pc), 32'h1234);
    check("jmp_noclr", 32'(ccr_out), 32'h6);
    cycle(3'b111, 3'b000, 1'b1, 2'd3, 16'h5555, 1'b0, 1'b0);
    check("squash_taken", 32'(br_taken), 32'd0);
    check("squash_pc", 32'(br_pc), 32'h1234);
    check("squash_we", 32'(ccr_out), 32'h6);

    // Randomized traffic
    hold_req = 0;
    for (int n = 0; n < 600; n++) begin
      if (!hold_req && $urandom_range(0, 9) == 0) hold_req = 1;
      cycle(3'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom),
            16'($urandom), hold_req, ($urandom_range(0, 5) == 0));
      if (m_ack) hold_req = 0;
    end

    // Asynchronous reset with a pulse pending
    set_ccr(3'b111);
    cycle(3'b000, 3'b000, 1'b1, 2'd0, 16'hBEEF, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_ccr", 32'(ccr_out), 32'd0);
    check("arst_taken", 32'(br_taken), 32'd0);
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_pc", 32'(br_pc), 32'd0);
    check("arst_ack", 32'(int_ack), 32'd0);
    check("arst_in_int", 32'(in_int), 32'd0);
    int_req = 1'b0;
    br_en   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
